aes_cipher_iter: RTL and testbench

AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

---
 rtl/aes_cipher_iter.sv | 157 +++++++++++++++
 tb/tb_aes_cipher_iter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock, one block in flight at a time.
// Optional define AES_CIPHER_KEY_LATCH_EN captures ExpandedKeys at accept so the source may change.
module aes_cipher_iter #(
  parameter int unsigned NR = 10,
  parameter int unsigned NK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           in_data,
  input  logic [128*(NR+1)-1:0]  ExpandedKeys,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           out_data,
  output logic                   busy
);

  localparam int unsigned KW = 128 * (NR + 1);
  localparam int unsigned CW = $clog2(NR + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  if (NR != NK + 6) begin : g_cfg_err
    $error("aes_cipher_iter: NR must equal NK + 6");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] f_sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] f_xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] f_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {f_xt(a0) ^ f_xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ f_xt(a1) ^ f_xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ f_xt(a2) ^ f_xt(a3) ^ a3,
            f_xt(a0) ^ a0 ^ a1 ^ a2 ^ f_xt(a3)};
  endfunction

  logic [1:0]    r_fsm;
  logic [CW-1:0] r_cnt;
  logic [127:0]  r_st;

  logic          w_accept;
  logic [KW-1:0] w_keys;
  logic [127:0]  w_rk, w_sb, w_sr, w_mc, w_round;

  assign w_accept = in_valid && (r_fsm == StIdle);

`ifdef AES_CIPHER_KEY_LATCH_EN
  logic [KW-1:0] r_keys;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_keys <= '0;
    end else if (w_accept) begin
      r_keys <= ExpandedKeys;
    end
  end

  // Round 0 is applied on the accept edge itself, before the copy is visible.
  assign w_keys = (r_fsm == StIdle) ? ExpandedKeys : r_keys;
`else
  assign w_keys = ExpandedKeys;
`endif

  // Counter is 0 whenever idle, so it directly selects round key 0 at accept.
  always_comb begin
    w_rk = '0;
    for (int r = 0; r <= int'(NR); r++) begin
      if (r_cnt == CW'(r)) w_rk = w_keys[KW-1-128*r -: 128];
    end
  end

  always_comb begin
    w_sb = '0;
    w_sr = '0;
    w_mc = '0;
    for (int i = 0; i < 16; i++) begin
      w_sb[127-8*i -: 8] = f_sbox(r_st[127-8*i -: 8]);
    end
    // Byte index is 4*column + row; row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mc[127-32*c -: 32] = f_mix(w_sr[127-32*c -: 32]);
    end
  end

  assign w_round = (r_cnt == CW'(NR)) ? (w_sr ^ w_rk) : (w_mc ^ w_rk);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm <= StIdle;
      r_cnt <= '0;
      r_st  <= '0;
    end else begin
      case (r_fsm)
        StIdle: begin
          if (in_valid) begin
            r_st  <= in_data ^ w_rk;
            r_cnt <= CW'(1);
            r_fsm <= StRound;
          end
        end
        StRound: begin
          r_st <= w_round;
          if (r_cnt == CW'(NR)) begin
            r_fsm <= StDone;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_fsm <= StIdle;
            r_cnt <= '0;
          end
        end
        default: begin
          r_fsm <= StIdle;
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (r_fsm == StIdle);
  assign out_valid = (r_fsm == StDone);
  assign busy      = (r_fsm == StRound) || (r_fsm == StDone);
  assign out_data  = r_st;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors on an AES-128 and an AES-256 instance.
module tb_aes_cipher_iter;

  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [127:0]  a_in_data = '0, a_out_data;
  logic [1407:0] a_keys = '0;
  logic          b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [127:0]  b_in_data = '0, b_out_data;
  logic [1919:0] b_keys = '0;

  int tests = 0;
  int fails = 0;

  logic [7:0]    sb [256];
  logic [1919:0] ek1, ek2, ek3;

  always #5 clk = ~clk;

  aes_cipher_iter #(.NR(10), .NK(4)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .ExpandedKeys(a_keys), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  aes_cipher_iter #(.NR(14), .NK(8)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .ExpandedKeys(b_keys), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse (x^254) and the affine map.
  task automatic build_sbox();
    logic [7:0] r, s;
    for (int x = 0; x < 256; x++) begin
      r = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, 8'(x));
      s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ek;
    rc = 8'h01;
    ek = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4 * (nr + 1); i++) ek[1919-32*i -: 32] = w[i];
    return ek;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_out_data !== '0) begin
      fails++;
      $display("FAIL reset_a: rdy=%b vld=%b busy=%b data=%h want 1 0 0 0",
               a_in_ready, a_out_valid, a_busy, a_out_data);
    end
    tests++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: rdy=%b vld=%b busy=%b want 1 0 0", b_in_ready, b_out_valid, b_busy);
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_aes128();
    int n;
    a_in_data = P1;
    a_keys = ek1[1919 -: 1408];
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tests++;
    if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL aes128_busy: busy=%b rdy=%b want 1 0", a_busy, a_in_ready);
    end
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 10) begin
      fails++;
      $display("FAIL aes128_latency: got %0d want 10", n);
    end
    tests++;
    if (a_out_data !== C1) begin
      fails++;
      $display("FAIL aes128_ct: got %h want %h", a_out_data, C1);
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    tests++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL aes128_release: vld=%b rdy=%b busy=%b want 0 1 0",
               a_out_valid, a_in_ready, a_busy);
    end
  endtask

  // Also drives in_valid/out_ready while busy: both must be ignored until DONE.
  task automatic test_backpressure();
    int n;
    a_in_data = P2;
    a_keys = ek2[1919 -: 1408];
    a_in_valid = 1'b1;
    tick();
    a_in_data = P1;
    a_out_ready = 1'b1;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    a_out_ready = 1'b0;
    tests++;
    if (n !== 10 || a_out_data !== C2) begin
      fails++;
      $display("FAIL bp_ct: got %h after %0d want %h after 10", a_out_data, n, C2);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (a_out_valid !== 1'b1 || a_out_data !== C2 || a_in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b data=%h want 1 0 %h",
                 k, a_out_valid, a_in_ready, a_out_data, C2);
      end
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: rdy=%b vld=%b want 1 0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_aes256();
    int n;
    b_in_data = P1;
    b_keys = ek3;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    n = 0;
    while (b_out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 14) begin
      fails++;
      $display("FAIL aes256_latency: got %0d want 14", n);
    end
    tests++;
    if (b_out_data !== C3) begin
      fails++;
      $display("FAIL aes256_ct: got %h want %h", b_out_data, C3);
    end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    int n;
    a_in_data = P1;
    a_keys = ek1[1919 -: 1408];
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    #1;
    tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_out_data !== '0) begin
      fails++;
      $display("FAIL midreset_async: rdy=%b vld=%b busy=%b data=%h want 1 0 0 0",
               a_in_ready, a_out_valid, a_busy, a_out_data);
    end
    #1 reset = 1'b0;
    a_out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (a_out_valid === 1'b1) seen++;
    end
    a_out_ready = 1'b0;
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL midreset_no_output: got %0d out_valid cycles want 0", seen);
    end
    a_in_data = P2;
    a_keys = ek2[1919 -: 1408];
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 10 || a_out_data !== C2) begin
      fails++;
      $display("FAIL midreset_recover: got %h after %0d want %h after 10", a_out_data, n, C2);
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, acc, outc;
    int acc_t [3];
    logic [127:0] exp_ct [3];
    exp_ct[0] = C1;
    exp_ct[1] = C2;
    exp_ct[2] = C1;
    cyc = 0;
    acc = 0;
    outc = 0;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    while (outc < 3 && cyc < 100) begin
      if (a_out_valid === 1'b1) begin
        tests++;
        if (a_out_data !== exp_ct[outc]) begin
          fails++;
          $display("FAIL b2b_ct%0d: got %h want %h", outc, a_out_data, exp_ct[outc]);
        end
        outc++;
      end
      if (a_in_ready === 1'b1) begin
        if (acc < 3) begin
          a_in_data = (acc == 1) ? P2 : P1;
          a_keys = (acc == 1) ? ek2[1919 -: 1408] : ek1[1919 -: 1408];
          acc_t[acc] = cyc;
          acc++;
        end else begin
          a_in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    tests++;
    if (outc !== 3 || acc !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d outputs %0d accepts want 3 3", outc, acc);
    end else begin
      tests++;
      if (acc_t[1] - acc_t[0] !== 12 || acc_t[2] - acc_t[1] !== 12) begin
        fails++;
        $display("FAIL b2b_spacing: got %0d,%0d want 12,12",
                 acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
      end
    end
    tick();
  endtask

`ifdef AES_CIPHER_KEY_LATCH_EN
  task automatic test_key_latch();
    int n;
    a_in_data = P1;
    a_keys = ek1[1919 -: 1408];
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_keys = ~ek1[1919 -: 1408];
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 10 || a_out_data !== C1) begin
      fails++;
      $display("FAIL key_latch_ct: got %h after %0d want %h after 10", a_out_data, n, C1);
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask
`endif

  initial begin
    build_sbox();
    ek1 = expand({K1, 128'h0}, 4, 10);
    ek2 = expand({K2, 128'h0}, 4, 10);
    ek3 = expand(K3, 8, 14);
    test_reset();
    test_aes128();
    test_backpressure();
    test_aes256();
    test_reset_mid();
    test_back_to_back();
`ifdef AES_CIPHER_KEY_LATCH_EN
    test_key_latch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
